// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the 128x9 instruction ROM: zero-latency fetch, jumps, branches, stall, halt.
// Optional FETCH_CYCLE_COUNT_EN adds a saturating cycle_count of clock edges spent in RUN.
module fetch_sequencer #(
    parameter int         NUM_INSTR  = 128,
    parameter logic [6:0] START_ADDR = 7'd0,
    parameter logic [8:0] HALT_WORD  = 9'h1FF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    input  logic       jump_en,
    input  logic [6:0] jump_target,
    input  logic       branch_en,
    input  logic [5:0] branch_offset,
    output logic [6:0] rom_address,
    input  logic [8:0] rom_instr,
    output logic [8:0] instr,
    output logic       instr_valid,
    output logic       done,
    output logic       fault
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    output logic [15:0] cycle_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [8:0] PC_LIMIT = 9'(NUM_INSTR);

    state_t     state, state_next;
    logic [6:0] pc, pc_next;
    logic       fault_q, fault_next;
    logic       is_halt;
    logic [7:0] seq_pc;
    logic [7:0] branch_pc;
    logic [7:0] redirect_pc;

    assign is_halt     = (rom_instr == HALT_WORD);
    assign rom_address = pc;
    assign instr       = rom_instr;
    assign instr_valid = (state == RUN) && !stall && !is_halt;
    assign done        = (state == DONE);
    assign fault       = fault_q;

    // A negative branch result wraps to >= 8'hE0 in 8 bits, so one unsigned
    // range compare catches both underflow and overrun.
    assign seq_pc      = {1'b0, pc} + 8'd1;
    assign branch_pc   = {1'b0, pc} + {{2{branch_offset[5]}}, branch_offset};
    assign redirect_pc = jump_en ? {1'b0, jump_target} : branch_pc;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_next = state;
        pc_next    = pc;
        fault_next = fault_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = START_ADDR;
                    fault_next = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (is_halt) begin
                        state_next = DONE;
                    end else if (jump_en || branch_en) begin
                        if ({1'b0, redirect_pc} >= PC_LIMIT) begin
                            state_next = DONE;
                            fault_next = 1'b1;
                        end else begin
                            pc_next = redirect_pc[6:0];
                        end
                    end else if ({1'b0, seq_pc} >= PC_LIMIT) begin
                        state_next = DONE;
                    end else begin
                        pc_next = seq_pc[6:0];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state   <= IDLE;
            pc      <= START_ADDR;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            fault_q <= fault_next;
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= 16'd0;
        end else if (state != RUN && start) begin
            cycle_count <= 16'd0;
        end else if (state == RUN && cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural 128x9 ROM driven off rom_address.
// Covers reset, straight-line fetch, jump/branch priority, stall, range faults, end of ROM and mid-run reset.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stall;
    logic       jump_en;
    logic [6:0] jump_target;
    logic       branch_en;
    logic [5:0] branch_offset;
    logic [6:0] rom_address;
    logic [8:0] rom_instr;
    logic [8:0] instr;
    logic       instr_valid;
    logic       done;
    logic       fault;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    logic [8:0] rom [128];
    int vectors = 0;
    int miscompares = 0;

    assign rom_instr = rom[rom_address];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .branch_en    (branch_en),
        .branch_offset(branch_offset),
        .rom_address  (rom_address),
        .rom_instr    (rom_instr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .done         (done),
        .fault        (fault)
`ifdef FETCH_CYCLE_COUNT_EN
        ,
        .cycle_count  (cycle_count)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
    endtask

    task automatic jump_to(input logic [6:0] target);
        jump_en     = 1'b1;
        jump_target = target;
        step();
        jump_en = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        jump_en = 1'b0;
        jump_target = 7'd0;
        branch_en = 1'b0;
        branch_offset = 6'd0;
        for (int i = 0; i < 128; i++) rom[i] = 9'(i);
        rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h004;
        rom[4] = 9'h005; rom[5] = 9'h1FF;

        // Reset state
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_done", 16'(done), 16'd0);
        check("rst_fault", 16'(fault), 16'd0);
        check("rst_valid", 16'(instr_valid), 16'd0);
        check("rst_addr", 16'(rom_address), 16'd0);

        // Straight line to the halt word at address 5
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            check("sl_addr", 16'(rom_address), 16'(k));
            check("sl_valid", 16'(instr_valid), 16'd1);
            check("sl_instr", 16'(instr), 16'(k + 1));
            step();
        end
        check("sl_halt_valid", 16'(instr_valid), 16'd0);
        check("sl_halt_done", 16'(done), 16'd0);
        step();
        check("sl_done", 16'(done), 16'd1);
        check("sl_fault", 16'(fault), 16'd0);
        check("sl_hold_addr", 16'(rom_address), 16'd5);

        // Jump beats branch when both are asserted
        rom[5] = 9'h005;
        pulse_start();
        check("jb_restart_done", 16'(done), 16'd0);
        step(); step(); step();
        check("jb_pc3", 16'(rom_address), 16'd3);
        jump_en = 1'b1; jump_target = 7'd20;
        branch_en = 1'b1; branch_offset = 6'b111110;
        step();
        jump_en = 1'b0; branch_en = 1'b0;
        #1;
        check("jb_pc20", 16'(rom_address), 16'd20);

        // Backward branch, then out-of-range branch
        jump_to(7'd10);
        check("bb_pc10", 16'(rom_address), 16'd10);
        branch_en = 1'b1; branch_offset = 6'b111101;
        step();
        branch_en = 1'b0;
        #1;
        check("bb_pc7", 16'(rom_address), 16'd7);
        jump_to(7'd2);
        branch_en = 1'b1; branch_offset = 6'b111011;
        step();
        branch_en = 1'b0;
        #1;
        check("oor_done", 16'(done), 16'd1);
        check("oor_fault", 16'(fault), 16'd1);
        check("oor_addr", 16'(rom_address), 16'd2);
        check("oor_valid", 16'(instr_valid), 16'd0);

        // Stall holds PC and ignores a pending jump until release
        pulse_start();
        check("st_fault_clr", 16'(fault), 16'd0);
        check("st_done_clr", 16'(done), 16'd0);
        check("st_pc0", 16'(rom_address), 16'd0);
        jump_to(7'd5);
        stall = 1'b1; jump_en = 1'b1; jump_target = 7'd30;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("st_addr", 16'(rom_address), 16'd5);
            check("st_valid", 16'(instr_valid), 16'd0);
            step();
        end
        check("st_addr_after", 16'(rom_address), 16'd5);
        stall = 1'b0;
        step();
        jump_en = 1'b0;
        #1;
        check("st_jump_taken", 16'(rom_address), 16'd30);
`ifdef FETCH_CYCLE_COUNT_EN
        check("st_cycle_count", cycle_count, 16'd5);
`endif

        // Running off the end of the ROM
        jump_to(7'd126);
        check("eor_pc126", 16'(rom_address), 16'd126);
        check("eor_valid126", 16'(instr_valid), 16'd1);
        step();
        check("eor_pc127", 16'(rom_address), 16'd127);
        check("eor_instr127", 16'(instr), 16'd127);
        step();
        check("eor_done", 16'(done), 16'd1);
        check("eor_fault", 16'(fault), 16'd0);
        check("eor_addr", 16'(rom_address), 16'd127);
        pulse_start();
        check("eor_restart_pc", 16'(rom_address), 16'd0);
        step();
        pulse_start();
        check("run_start_ignored", 16'(rom_address), 16'd2);

        // Reset in the middle of RUN
        jump_to(7'd40);
        check("mr_pc40", 16'(rom_address), 16'd40);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mr_valid", 16'(instr_valid), 16'd0);
        check("mr_addr", 16'(rom_address), 16'd0);
        check("mr_done", 16'(done), 16'd0);
`ifdef FETCH_CYCLE_COUNT_EN
        check("mr_cycle_count", cycle_count, 16'd0);
`endif
        step();
        check("mr_idle_valid", 16'(instr_valid), 16'd0);
        check("mr_idle_addr", 16'(rom_address), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
